// File: rtl/fp_mul_seq.sv
// fp_mul_seq - sequential IEEE-754 single-precision multiplier.
//
// The significand product is built by a shift-and-add loop, one multiplier
// bit per clock, LSB first. The product is then normalised, truncated
// (no rounding) and packed. Special operand classes (zero/denormal, inf,
// NaN) are classified when the operands are latched. They override the
// arithmetic result, but the latency stays the same for every operand class.
//
// Ports:
//   clk    - clock, rising edge active
//   rst_n  - asynchronous active-low reset; aborts any operation in flight
//   start  - request, only sampled while idle
//   a, b   - IEEE-754 single-precision operands, latched on the accepted start
//   busy   - high from the accepted start until the cycle after done
//   done   - one-cycle pulse marking res as valid
//   res    - product, held until the next done
module fp_mul_seq #(
    parameter int MANT_W   = 24,
    parameter int EXP_BIAS = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t              state, state_next;
    logic [PROD_W-1:0]   mcand;
    logic [MANT_W-1:0]   mplier;
    logic [PROD_W-1:0]   prod;
    logic [CNT_W-1:0]    cnt;
    logic                sign_r;
    logic signed [9:0]   exp_r;
    logic                sp_nan, sp_inf, sp_zero;

    logic                a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic                cls_nan, cls_inf, cls_zero;
    logic                top;
    logic signed [9:0]   exp_n;
    logic [22:0]         frac_n;
    logic [31:0]         res_next;

    // Operand classification. Denormals are flushed to zero. The result
    // class is resolved in priority order: NaN, then infinity, then zero.
    always_comb begin
        a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        a_zero   = (a[30:23] == 8'h00);
        b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        b_zero   = (b[30:23] == 8'h00);
        cls_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        cls_inf  = !cls_nan && (a_inf || b_inf);
        cls_zero = !cls_nan && !cls_inf && (a_zero || b_zero);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic. The DONE state exists so that a start coincident
    // with the done pulse's trailing edge is ignored.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (start) state_next = MUL;
            MUL:  if (cnt == CNT_W'(MANT_W - 1)) state_next = NORM;
            NORM: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Normalisation and packing of the finished product. A product with its
    // top bit set is in [2,4) and needs the exponent bumped by one.
    // Range checks happen after that adjustment.
    always_comb begin
        top    = prod[PROD_W-1];
        exp_n  = exp_r + (top ? 10'sd1 : 10'sd0);
        frac_n = top ? prod[PROD_W-2 -: 23] : prod[PROD_W-3 -: 23];
        if (sp_nan)
            res_next = 32'h7FC0_0000;
        else if (sp_inf)
            res_next = {sign_r, 8'hFF, 23'd0};
        else if (sp_zero)
            res_next = {sign_r, 31'd0};
        else if (exp_n >= 10'sd255)
            res_next = {sign_r, 8'hFF, 23'd0};
        else if (exp_n <= 10'sd0)
            res_next = {sign_r, 31'd0};
        else
            res_next = {sign_r, exp_n[7:0], frac_n};
    end

    // Datapath. Operands are captured and classified on the accepted start.
    // The multiplicand is shifted left each step, so adding it directly
    // contributes multiplicand<<i. res changes only on the NORM edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            cnt     <= '0;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            sp_nan  <= 1'b0;
            sp_inf  <= 1'b0;
            sp_zero <= 1'b0;
            done    <= 1'b0;
            res     <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= PROD_W'({1'b1, a[22:0]});
                        mplier  <= MANT_W'({1'b1, b[22:0]});
                        prod    <= '0;
                        cnt     <= '0;
                        sign_r  <= a[31] ^ b[31];
                        exp_r   <= 10'({2'b00, a[30:23]}) + 10'({2'b00, b[30:23]})
                                   - 10'(EXP_BIAS);
                        sp_nan  <= cls_nan;
                        sp_inf  <= cls_inf;
                        sp_zero <= cls_zero;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                NORM: begin
                    res  <= res_next;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq - directed testbench for fp_mul_seq.
//
// Each scenario task drives its own vectors and checks results inline
// against hand-computed IEEE-754 values, the fixed 25-edge done latency,
// 26 busy cycles and a single done pulse per operation.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mul_seq #(.MANT_W(24), .EXP_BIAS(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation from an idle DUT. lat is the number of edges after
    // the accepting edge until done is seen (-1 if never). Operands are
    // scrambled after the accepting edge to show they were latched.
    task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                         output logic [31:0] r, output int lat,
                         output int busy_cyc, output int done_cnt);
        a = ai; b = bi; start = 1'b1;
        r = 32'h0; lat = -1; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
        busy_cyc = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin lat = n; r = res; end
            end
            if (!busy && lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = 32'h0; b = 32'h0;
        #12;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_res got %h want 00000000", res); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_arith();
        logic [31:0] va [3] = '{32'h40000000, 32'h3FC00000, 32'hC0200000};
        logic [31:0] vb [3] = '{32'h40400000, 32'h3FC00000, 32'h40800000};
        logic [31:0] ve [3] = '{32'h40C00000, 32'h40100000, 32'hC1200000};
        logic [31:0] r;
        int lat, bc, dc;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], r, lat, bc, dc);
            n_checks++;
            if (r !== ve[i]) begin n_fail++; $display("[TB] FAIL arith_res[%0d] got %h want %h", i, r, ve[i]); end
            n_checks++;
            if (lat !== 25) begin n_fail++; $display("[TB] FAIL arith_lat[%0d] got %0d want 25", i, lat); end
            n_checks++;
            if (bc !== 26) begin n_fail++; $display("[TB] FAIL arith_busy[%0d] got %0d want 26", i, bc); end
            n_checks++;
            if (dc !== 1) begin n_fail++; $display("[TB] FAIL arith_done_cnt[%0d] got %0d want 1", i, dc); end
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (res !== 32'hC1200000) begin n_fail++; $display("[TB] FAIL res_hold got %h want c1200000", res); end
    endtask

    task automatic test_boundaries_specials();
        logic [31:0] va [6] = '{32'h7F000000, 32'h00800000, 32'h80000000,
                                32'h7F800000, 32'h7FC00001, 32'hFF800000};
        logic [31:0] vb [6] = '{32'h7F000000, 32'h00800000, 32'h40000000,
                                32'h00000000, 32'h3F800000, 32'h40000000};
        logic [31:0] ve [6] = '{32'h7F800000, 32'h00000000, 32'h80000000,
                                32'h7FC00000, 32'h7FC00000, 32'hFF800000};
        logic [31:0] r;
        int lat, bc, dc;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], r, lat, bc, dc);
            n_checks++;
            if (r !== ve[i]) begin n_fail++; $display("[TB] FAIL edge_res[%0d] got %h want %h", i, r, ve[i]); end
            n_checks++;
            if (lat !== 25) begin n_fail++; $display("[TB] FAIL edge_lat[%0d] got %0d want 25", i, lat); end
            n_checks++;
            if (bc !== 26) begin n_fail++; $display("[TB] FAIL edge_busy[%0d] got %0d want 26", i, bc); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int lat, dc;
        a = 32'h40000000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h3FC00000; b = 32'h3FC00000;
        dc = 0; r = 32'h0; lat = -1;
        for (int n = 1; n <= 26; n++) begin
            @(posedge clk); #1;
            if (n == 4) start = 1'b1;
            if (n == 5) start = 1'b0;
            if (done) begin dc++; r = res; lat = n; end
            if (n == 25) start = 1'b1;
        end
        n_checks++;
        if (dc !== 1) begin n_fail++; $display("[TB] FAIL busy_start_done_cnt got %0d want 1", dc); end
        n_checks++;
        if (r !== 32'h40C00000) begin n_fail++; $display("[TB] FAIL busy_start_res got %h want 40c00000", r); end
        n_checks++;
        if (lat !== 25) begin n_fail++; $display("[TB] FAIL busy_start_lat got %0d want 25", lat); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL start_in_done_ignored got busy=%b want 0", busy); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL start_after_done_accepted got busy=%b want 1", busy); end
        start = 1'b0;
        lat = -1; r = 32'h0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done && lat < 0) begin lat = n; r = res; end
            if (!busy && lat >= 0) break;
        end
        n_checks++;
        if (r !== 32'h40100000) begin n_fail++; $display("[TB] FAIL restart_res got %h want 40100000", r); end
        n_checks++;
        if (lat !== 25) begin n_fail++; $display("[TB] FAIL restart_lat got %0d want 25", lat); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        int lat, bc, dc;
        a = 32'h40000000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_done got %b want 0", done); end
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("[TB] FAIL midreset_res got %h want 00000000", res); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dc++;
        end
        n_checks++;
        if (dc !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_done got %0d pulses want 0", dc); end
        do_op(32'hC0200000, 32'h40800000, r, lat, bc, dc);
        n_checks++;
        if (r !== 32'hC1200000) begin n_fail++; $display("[TB] FAIL post_reset_res got %h want c1200000", r); end
        n_checks++;
        if (lat !== 25) begin n_fail++; $display("[TB] FAIL post_reset_lat got %0d want 25", lat); end
    endtask

    // Watchdog so a stuck run still terminates with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_boundaries_specials();
        test_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
